// File: rtl/rvh_l1d_mshr_file_if.sv
// ---------------------------------------------------------------------------
// rvh_l1d_mshr_file_if
// Bundles every non-clock/reset signal of the L1D MSHR file.
//   new_req_*   : primary miss from the L1D pipeline (+ hit/ready/id back)
//   alloc_*     : allocator's chosen slot and free flag, mshr_bank_valid_o to it
//   l2_req_*    : line-fill request toward L2 (valid/ready)
//   l2_resp_*   : fill response from L2 (always accepted)
//   refill_*    : completed entry handed to the refill path (valid/ready)
// Signal suffixes are from the MSHR file's point of view.
// modport slave  : the MSHR file itself
// modport master : its environment (pipeline, allocator, L2, refill path)
// ---------------------------------------------------------------------------
interface rvh_l1d_mshr_file_if #(
    parameter int N_MSHR      = 4,
    parameter int N_MSHR_W    = (N_MSHR > 1) ? $clog2(N_MSHR) : 1,
    parameter int LINE_ADDR_W = 50,
    parameter int REQ_INFO_W  = 16
);
    logic                   new_req_vld_i;
    logic [LINE_ADDR_W-1:0] new_req_line_addr_i;
    logic [REQ_INFO_W-1:0]  new_req_info_i;
    logic                   new_req_rdy_o;
    logic                   new_req_addr_hit_o;
    logic [N_MSHR_W-1:0]    new_req_mshr_id_o;

    logic [N_MSHR-1:0]      mshr_bank_valid_o;
    logic [N_MSHR_W-1:0]    alloc_mshr_id_i;
    logic                   alloc_has_free_i;

    logic                   l2_req_vld_o;
    logic                   l2_req_rdy_i;
    logic [LINE_ADDR_W-1:0] l2_req_line_addr_o;
    logic [N_MSHR_W-1:0]    l2_req_mshr_id_o;

    logic                   l2_resp_vld_i;
    logic [N_MSHR_W-1:0]    l2_resp_mshr_id_i;

    logic                   refill_vld_o;
    logic                   refill_rdy_i;
    logic [N_MSHR_W-1:0]    refill_mshr_id_o;
    logic [LINE_ADDR_W-1:0] refill_line_addr_o;
    logic [REQ_INFO_W-1:0]  refill_info_o;

    modport slave (
        input  new_req_vld_i, new_req_line_addr_i, new_req_info_i,
        output new_req_rdy_o, new_req_addr_hit_o, new_req_mshr_id_o,
        output mshr_bank_valid_o,
        input  alloc_mshr_id_i, alloc_has_free_i,
        output l2_req_vld_o, l2_req_line_addr_o, l2_req_mshr_id_o,
        input  l2_req_rdy_i,
        input  l2_resp_vld_i, l2_resp_mshr_id_i,
        output refill_vld_o, refill_mshr_id_o, refill_line_addr_o, refill_info_o,
        input  refill_rdy_i
    );

    modport master (
        output new_req_vld_i, new_req_line_addr_i, new_req_info_i,
        input  new_req_rdy_o, new_req_addr_hit_o, new_req_mshr_id_o,
        input  mshr_bank_valid_o,
        output alloc_mshr_id_i, alloc_has_free_i,
        input  l2_req_vld_o, l2_req_line_addr_o, l2_req_mshr_id_o,
        output l2_req_rdy_i,
        output l2_resp_vld_i, l2_resp_mshr_id_i,
        input  refill_vld_o, refill_mshr_id_o, refill_line_addr_o, refill_info_o,
        output refill_rdy_i
    );
endinterface

// File: rtl/rvh_l1d_mshr_file.sv
// ---------------------------------------------------------------------------
// rvh_l1d_mshr_file
// Per-entry state and bookkeeping for the L1D miss-status holding registers.
// A miss is allocated into the allocator-chosen slot, a line-fill request is
// sent to L2 (round-robin among pending entries), the L2 response marks the
// entry complete, and the lowest-index complete entry is handed to refill.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous, active-low reset
//   bus  : rvh_l1d_mshr_file_if.slave (miss request, allocator, L2 request,
//          L2 response and refill channels)
// ---------------------------------------------------------------------------

// One MSHR entry: 2-bit state plus captured line address and payload.
// Each event input only acts in the state it applies to, so stray events
// (e.g. a response to a non-WAIT entry) are ignored here.
module rvh_l1d_mshr_entry #(
    parameter int LINE_ADDR_W = 50,
    parameter int REQ_INFO_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alloc_i,
    input  logic [LINE_ADDR_W-1:0] line_addr_i,
    input  logic [REQ_INFO_W-1:0]  info_i,
    input  logic                   l2_hsk_i,
    input  logic                   resp_i,
    input  logic                   refill_hsk_i,
    output logic [1:0]             state_o,
    output logic [LINE_ADDR_W-1:0] line_addr_o,
    output logic [REQ_INFO_W-1:0]  info_o
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SEND   = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_REFILL = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [LINE_ADDR_W-1:0] addr_q;
    logic [REQ_INFO_W-1:0]  info_q;
    logic                   capture;

    assign capture = alloc_i && (state_q == ST_IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (alloc_i)      state_d = ST_SEND;
            ST_SEND:   if (l2_hsk_i)     state_d = ST_WAIT;
            ST_WAIT:   if (resp_i)       state_d = ST_REFILL;
            ST_REFILL: if (refill_hsk_i) state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            info_q  <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                addr_q <= line_addr_i;
                info_q <= info_i;
            end
        end
    end

    assign state_o     = state_q;
    assign line_addr_o = addr_q;
    assign info_o      = info_q;
endmodule

module rvh_l1d_mshr_file #(
    parameter int N_MSHR      = 4,
    parameter int N_MSHR_W    = (N_MSHR > 1) ? $clog2(N_MSHR) : 1,
    parameter int LINE_ADDR_W = 50,
    parameter int REQ_INFO_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    rvh_l1d_mshr_file_if.slave    bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SEND   = 2'd1;
    localparam logic [1:0] ST_REFILL = 2'd3;

    logic [N_MSHR-1:0][1:0]             ent_state;
    logic [N_MSHR-1:0][LINE_ADDR_W-1:0] ent_addr;
    logic [N_MSHR-1:0][REQ_INFO_W-1:0]  ent_info;

    logic [N_MSHR-1:0] valid_vec, send_vec, refill_vec;
    logic [N_MSHR-1:0] alloc_en, l2_hsk_en, resp_en, refill_en;

    logic                addr_hit, req_rdy, alloc_fire;
    logic                pick_found;
    logic [N_MSHR_W-1:0] pick_id, l2_id, ref_id;
    logic                l2_vld, l2_hsk, ref_vld, ref_hsk;

    // Round-robin pointer and grant lock. The lock holds the presented ID
    // stable while L2 stalls, so late SEND arrivals cannot steal the slot.
    logic                rr_q, lock_q;
    logic [N_MSHR_W-1:0] rr_ptr_q, lock_id_q;
    logic [N_MSHR_W-1:0] rr_ptr_d;

    // ---------------- entries ----------------
    for (genvar i = 0; i < N_MSHR; i++) begin : g_ent
        assign valid_vec[i]  = (ent_state[i] != ST_IDLE);
        assign send_vec[i]   = (ent_state[i] == ST_SEND);
        assign refill_vec[i] = (ent_state[i] == ST_REFILL);

        assign alloc_en[i]  = alloc_fire && (bus.alloc_mshr_id_i == N_MSHR_W'(i));
        assign l2_hsk_en[i] = l2_hsk && (l2_id == N_MSHR_W'(i));
        assign resp_en[i]   = bus.l2_resp_vld_i && (bus.l2_resp_mshr_id_i == N_MSHR_W'(i));
        assign refill_en[i] = ref_hsk && (ref_id == N_MSHR_W'(i));

        rvh_l1d_mshr_entry #(
            .LINE_ADDR_W (LINE_ADDR_W),
            .REQ_INFO_W  (REQ_INFO_W)
        ) u_ent (
            .clk          (clk),
            .rst          (rst),
            .alloc_i      (alloc_en[i]),
            .line_addr_i  (bus.new_req_line_addr_i),
            .info_i       (bus.new_req_info_i),
            .l2_hsk_i     (l2_hsk_en[i]),
            .resp_i       (resp_en[i]),
            .refill_hsk_i (refill_en[i]),
            .state_o      (ent_state[i]),
            .line_addr_o  (ent_addr[i]),
            .info_o       (ent_info[i])
        );
    end

    // ---------------- new request ----------------
    always_comb begin
        addr_hit = 1'b0;
        for (int i = 0; i < N_MSHR; i++) begin
            if (valid_vec[i] && (ent_addr[i] == bus.new_req_line_addr_i)) addr_hit = 1'b1;
        end
    end

    assign req_rdy    = bus.alloc_has_free_i && !addr_hit;
    assign alloc_fire = bus.new_req_vld_i && req_rdy;

    assign bus.new_req_rdy_o      = req_rdy;
    assign bus.new_req_addr_hit_o = addr_hit;
    assign bus.new_req_mshr_id_o  = bus.alloc_mshr_id_i;
    assign bus.mshr_bank_valid_o  = valid_vec;

    // ---------------- L2 request arbitration ----------------
    always_comb begin
        int idx;
        pick_found = 1'b0;
        pick_id    = '0;
        for (int k = 0; k < N_MSHR; k++) begin
            idx = (int'(rr_ptr_q) + k) % N_MSHR;
            if (!pick_found && send_vec[idx]) begin
                pick_found = 1'b1;
                pick_id    = N_MSHR_W'(idx);
            end
        end
    end

    // A locked entry is still in SEND, so any-SEND is the valid.
    assign l2_vld = |send_vec;
    assign l2_id  = lock_q ? lock_id_q : pick_id;
    assign l2_hsk = l2_vld && bus.l2_req_rdy_i;

    assign rr_ptr_d = (l2_id == N_MSHR_W'(N_MSHR - 1)) ? '0 : l2_id + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q      <= 1'b0;
            rr_ptr_q  <= '0;
            lock_q    <= 1'b0;
            lock_id_q <= '0;
        end else begin
            rr_q <= 1'b0;
            if (l2_hsk) begin
                rr_ptr_q <= rr_ptr_d;
                lock_q   <= 1'b0;
            end else if (l2_vld) begin
                lock_q    <= 1'b1;
                lock_id_q <= l2_id;
            end
        end
    end

    assign bus.l2_req_vld_o       = l2_vld;
    assign bus.l2_req_mshr_id_o   = l2_vld ? l2_id : '0;
    assign bus.l2_req_line_addr_o = l2_vld ? ent_addr[l2_id] : '0;

    // ---------------- refill: lowest index wins ----------------
    always_comb begin
        ref_id = '0;
        for (int i = N_MSHR - 1; i >= 0; i--) begin
            if (refill_vec[i]) ref_id = N_MSHR_W'(i);
        end
    end

    assign ref_vld = |refill_vec;
    assign ref_hsk = ref_vld && bus.refill_rdy_i;

    assign bus.refill_vld_o       = ref_vld;
    assign bus.refill_mshr_id_o   = ref_vld ? ref_id : '0;
    assign bus.refill_line_addr_o = ref_vld ? ent_addr[ref_id] : '0;
    assign bus.refill_info_o      = ref_vld ? ent_info[ref_id] : '0;

    // rr_q is a spare bit kept at zero; fold it into nothing observable.
    logic unused_ok;
    assign unused_ok = rr_q;
endmodule

// File: doc/rvh_l1d_mshr_file.md
# rvh_l1d_mshr_file

Per-entry state and bookkeeping for the L1D miss-status holding registers. Accepts primary misses from the L1D pipeline, allocates entries in the slot chosen by the MSHR allocator, issues line-fill requests to L2 and receives their responses, then hands completed lines to the refill path. It sits directly upstream of the allocator: it drives the allocator's per-bank valid vector and consumes the allocator's chosen ID and availability flag.

## Interface
- N_MSHR, 4: number of entries.
- N_MSHR_W, 2: ID width. Equals clog2(N_MSHR), minimum 1.
- LINE_ADDR_W, 50: cache-line address width.
- REQ_INFO_W, 16: opaque per-miss payload, returned at refill.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- new_req_vld_i  in  1  miss request valid.
- new_req_line_addr_i  in  LINE_ADDR_W  miss line address.
- new_req_info_i  in  REQ_INFO_W  miss payload.
- new_req_rdy_o  out  1  request accepted this cycle when high with vld.
- new_req_addr_hit_o  out  1  request line matches a live entry. Pipeline must replay.
- new_req_mshr_id_o  out  N_MSHR_W  ID that is or would be allocated (alloc_mshr_id_i).
- mshr_bank_valid_o  out  N_MSHR  per-entry live flag, feeds the allocator.
- alloc_mshr_id_i  in  N_MSHR_W  allocator's lowest free index.
- alloc_has_free_i  in  1  allocator reports at least one free entry.
- l2_req_vld_o  out  1  line-fill request valid.
- l2_req_rdy_i  in  1  L2 accepts the request.
- l2_req_line_addr_o  out  LINE_ADDR_W  requested line.
- l2_req_mshr_id_o  out  N_MSHR_W  requesting entry.
- l2_resp_vld_i  in  1  fill response; always accepted.
- l2_resp_mshr_id_i  in  N_MSHR_W  entry the response targets.
- refill_vld_o  out  1  completed entry ready for refill.
- refill_rdy_i  in  1  refill path accepts.
- refill_mshr_id_o  out  N_MSHR_W  entry being refilled.
- refill_line_addr_o  out  LINE_ADDR_W  its line address.
- refill_info_o  out  REQ_INFO_W  its payload.

## Operation
- Each entry has a 2-bit state: IDLE=0, SEND=1, WAIT=2, REFILL=3. The entry also holds a line address and an info register.
- mshr_bank_valid_o[i] = (state[i] != IDLE). It is a pure register decode.
- Address hit: new_req_addr_hit_o = OR over i of (valid[i] & line_addr[i] == new_req_line_addr_i). It is combinational and independent of new_req_vld_i.
- Ready: new_req_rdy_o = alloc_has_free_i & ~new_req_addr_hit_o. It must not depend on new_req_vld_i.
- Allocation: on vld&rdy, entry alloc_mshr_id_i goes IDLE->SEND and captures the address and info.
- SEND arbitration: round-robin among SEND entries, starting from an rr pointer.
  - Once l2_req_vld_o rises, the chosen ID is locked until the handshake, even if new entries enter SEND.
  - On the handshake, the winner goes SEND->WAIT and the pointer moves to winner+1 (mod N_MSHR).
- WAIT: when l2_resp_vld_i targets an entry in WAIT, that entry goes WAIT->REFILL.
  - A response targeting a non-WAIT entry is ignored. The bench flags it with an assertion.
- REFILL: lowest-index REFILL entry drives the refill outputs. On refill_vld_o&refill_rdy_i it goes REFILL->IDLE.
- Outputs are don't-care when their valid is low. They are driven to 0 for determinism.

## Timing
- Reset: all entries IDLE, the rr pointer and lock are 0, and all outputs are 0. new_req_rdy_o then follows alloc_has_free_i.
- Reset asserted mid-operation drops every entry to IDLE immediately. In-flight L2 responses after reset are ignored.
- Alloc at cycle T: mshr_bank_valid_o goes high at T+1. The earliest l2_req_vld_o for that entry is T+1.
- L2 handshake at T: WAIT from T+1.
- Response at T: refill_vld_o is eligible at T+1.
- Refill handshake at T: the entry is IDLE at T+1, and its slot can be reallocated at T+1 at the earliest.
- A slot freed at T cannot be allocated at T, because the allocator sees the registered valid vector.
- A line freed at T still produces an address hit at T.
- Full: all entries live, so alloc_has_free_i=0 and new_req_rdy_o=0.
- The same cycle can carry alloc, L2 handshake, response and refill handshake on distinct entries; all take effect independently.
- A response and an L2 handshake never target the same entry in one cycle.
- No combinational path from l2_req_rdy_i or refill_rdy_i to any valid output.

## Test plan
- Single miss:
  - Stimulus: alloc 0x100 at T; l2_req_rdy_i=1; response at T+3; refill_rdy_i=1.
  - Required: l2_req_vld_o at T+1 with id 0; refill_vld_o at T+4; mshr_bank_valid_o returns to 0000 at T+5.
- Fill to full:
  - Stimulus: 4 misses to distinct lines on consecutive cycles, L2 stalled.
  - Required: mshr_bank_valid_o=1111 and new_req_rdy_o=0 from the 5th request; ids 0,1,2,3.
- Duplicate line:
  - Stimulus: second miss to 0x100 while entry 0 is WAIT.
  - Required: new_req_addr_hit_o=1, rdy=0, no allocation.
  - Stimulus: the same miss one cycle after the refill handshake.
  - Required: accepted.
- Round-robin and lock:
  - Stimulus: entries 0–3 in SEND, l2_req_rdy_i low for 3 cycles then high.
  - Required: the id stays constant while stalled; grant order is 0,1,2,3.
- Out-of-order responses:
  - Stimulus: responses for ids 2, 0, 3, 1; refill_rdy_i low.
  - Required: after all four, refill outputs ids 0,1,2,3 in that order once refill_rdy_i is raised.
  - Stimulus: a response to an IDLE id.
  - Required: no state change.
- Mid-flight reset:
  - Stimulus: rst low with 3 live entries.
  - Required: all outputs 0 immediately and mshr_bank_valid_o=0000.
  - Stimulus: a response arriving after reset.
  - Required: ignored.
